// File: rtl/hc_write_arbiter_pkg.sv
// Shared types for the CCI-P write-channel arbiter.
// hc_user_pkg holds the requestor control word; hc_write_arbiter_pkg holds the
// arbiter FSM encoding and the round-robin pick helper.
package hc_user_pkg;
   typedef enum logic [1:0] {
      e_REQUEST_NONE          = 2'd0,
      e_REQUEST_READ          = 2'd1,
      e_REQUEST_WRITE_STREAM  = 2'd2,
      e_REQUEST_WRITE_INDEXED = 2'd3
   } t_request_cmd;

   typedef struct packed {
      t_request_cmd cmd;
      logic [7:0]   id;
      logic [31:0]  offset;
   } t_request_control;
endpackage

package hc_write_arbiter_pkg;
   typedef enum logic [1:0] {S_ARB_IDLE, S_ARB_HOLD, S_ARB_FINISH} t_arb_state;

   localparam int HC_ARB_MAX_REQ = 8;
   localparam int HC_ARB_IDX_W   = 3;

   typedef struct packed {
      logic                    found;
      logic [HC_ARB_IDX_W-1:0] idx;
   } t_rr_pick;

   // First set bit of valid scanning ptr+1 .. ptr+num (mod num). The loop bound
   // is fixed at the maximum core count so it unrolls to a flat priority mux.
   function automatic t_rr_pick hc_rr_pick(input logic [HC_ARB_MAX_REQ-1:0] valid,
                                           input logic [HC_ARB_IDX_W-1:0]   ptr,
                                           input int unsigned               num);
      t_rr_pick                res;
      int unsigned             j;
      logic [HC_ARB_IDX_W-1:0] j_idx;
      res = '0;
      for (int unsigned k = 1; k <= HC_ARB_MAX_REQ; k++) begin
         if (k <= num) begin
            j     = (32'(ptr) + k) % num;
            j_idx = HC_ARB_IDX_W'(j);
            if (!res.found && valid[j_idx]) begin
               res.found = 1'b1;
               res.idx   = j_idx;
            end
         end
      end
      return res;
   endfunction
endpackage

// File: rtl/hc_write_arbiter_if.sv
// Bundle between the user cores / requestor and the write arbiter.
// master = core + requestor side, slave = arbiter.
interface hc_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int CL_W    = 512
);
   import hc_user_pkg::*;

   logic             [NUM_REQ-1:0]          req_valid;
   t_request_control [NUM_REQ-1:0]          req_ctrl;
   logic             [NUM_REQ-1:0][CL_W-1:0] req_data;
   logic             [NUM_REQ-1:0]          req_last;
   logic             [NUM_REQ-1:0]          req_ready;
   logic             [NUM_REQ-1:0]          req_done;
   logic                                    wr_full;
   t_request_control                        out_ctrl;
   logic             [CL_W-1:0]             out_data;
   logic             [$clog2(NUM_REQ)-1:0]  grant_id;
   logic                                    finish;
   logic             [NUM_REQ-1:0][31:0]    stat_grants;

   modport master (
      output req_valid, req_ctrl, req_data, req_last, req_done, wr_full,
      input  req_ready, out_ctrl, out_data, grant_id, finish, stat_grants
   );

   modport slave (
      input  req_valid, req_ctrl, req_data, req_last, req_done, wr_full,
      output req_ready, out_ctrl, out_data, grant_id, finish, stat_grants
   );
endinterface

// File: rtl/hc_write_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first valid core after ptr.
module hc_rr_picker
   import hc_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         valid,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic                       found,
   output logic [$clog2(NUM_REQ)-1:0] idx
);
   t_rr_pick pick;

   // Rotate-and-scan over the zero-extended valid vector.
   always_comb pick = hc_rr_pick(HC_ARB_MAX_REQ'(valid), HC_ARB_IDX_W'(ptr), NUM_REQ);

   assign found = pick.found;
   assign idx   = $clog2(NUM_REQ)'(pick.idx);
endmodule

// File: rtl/hc_write_arbiter.sv
// Round-robin write-channel arbiter with optional burst locking.
// Optional per-core accepted-line counters: define HC_WR_ARB_STATS_EN.
module hc_write_arbiter
   import hc_write_arbiter_pkg::*;
   import hc_user_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 8,
   parameter int CL_W     = 512
) (
   input logic              clk,
   input logic              reset,
   hc_write_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int HC_W  = $clog2(MAX_HOLD) + 1;
   localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(NUM_REQ - 1);
   localparam t_request_control CTRL_NONE = '{cmd: e_REQUEST_NONE, id: '0, offset: '0};

   t_arb_state        state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  grant_id;
   logic [HC_W-1:0]   hold_cnt;
   t_request_control  out_ctrl;
   logic [CL_W-1:0]   out_data;
   logic              finish;

   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic              xfer;
   logic [IDX_W-1:0]  sel;
   logic [NUM_REQ-1:0] ready;

   hc_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .valid (bus.req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Transfer decision: at most one core, never while full, reset or finished.
   always_comb begin
      xfer  = 1'b0;
      sel   = pick_idx;
      ready = '0;
      if (!reset) begin
         case (state)
            S_ARB_IDLE: xfer = pick_found && !bus.wr_full;
            S_ARB_HOLD: begin
               sel  = grant_id;
               xfer = bus.req_valid[grant_id] && !bus.wr_full;
            end
            default: xfer = 1'b0;
         endcase
      end
      if (xfer) ready[sel] = 1'b1;
   end

   // Arbitration FSM plus registered output stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_ARB_IDLE;
         rr_ptr   <= PTR_INIT;
         grant_id <= '0;
         hold_cnt <= '0;
         out_ctrl <= CTRL_NONE;
         out_data <= '0;
         finish   <= 1'b0;
      end else begin
         // The control word is only non-NONE for one cycle per accepted line.
         out_ctrl <= CTRL_NONE;
         if (xfer) begin
            out_ctrl <= bus.req_ctrl[sel];
            out_data <= bus.req_data[sel];
            grant_id <= sel;
         end
         case (state)
            S_ARB_IDLE: begin
               if (xfer) begin
                  rr_ptr <= sel;
                  if (!bus.req_last[sel] && MAX_HOLD > 1) begin
                     state    <= S_ARB_HOLD;
                     hold_cnt <= HC_W'(1);
                  end
               end else if (bus.req_valid == '0 && &bus.req_done) begin
                  state  <= S_ARB_FINISH;
                  finish <= 1'b1;
               end
            end
            S_ARB_HOLD: begin
               if (!bus.req_valid[grant_id]) begin
                  // Grantee went idle: release without a transfer.
                  state    <= S_ARB_IDLE;
                  hold_cnt <= '0;
               end else if (xfer) begin
                  if (bus.req_last[grant_id] || hold_cnt == HOLD_LAST) begin
                     state    <= S_ARB_IDLE;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               // wr_full with valid held: stay locked, count unchanged.
            end
            default: finish <= 1'b1;
         endcase
      end
   end

   assign bus.req_ready = ready;
   assign bus.out_ctrl  = out_ctrl;
   assign bus.out_data  = out_data;
   assign bus.grant_id  = grant_id;
   assign bus.finish    = finish;

`ifdef HC_WR_ARB_STATS_EN
   logic [NUM_REQ-1:0][31:0] stat_cnt;
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
      logic [31:0] cnt;
      // Accepted-line counter for core i; wraps naturally at 2^32.
      always_ff @(posedge clk) begin
         if (reset)         cnt <= '0;
         else if (ready[i]) cnt <= cnt + 32'd1;
      end
      assign stat_cnt[i] = cnt;
   end
   assign bus.stat_grants = stat_cnt;
`else
   assign bus.stat_grants = '0;
`endif
endmodule
